// File: rtl/entropy_pkg.sv
// -----------------------------------------------------------------------------
// entropy_pkg
// Shared types and constants for the entropy serial transmitter.
//   tx_state_t : transmit FSM states (idle, strobe low, strobe high, gap)
//   BYTE_W     : width of one entropy byte
//   FIFO_DEPTH : entries in the input queue
//   sel_bit    : picks the bit on the line for a given bit index and order
// -----------------------------------------------------------------------------
package entropy_pkg;

    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    // Bit idx of the outgoing sequence: counted from bit 7 when msb_first,
    // from bit 0 otherwise.
    function automatic logic sel_bit(
        input logic [BYTE_W-1:0] b,
        input logic [2:0]        idx,
        input logic              msb_first
    );
        logic [2:0] pos;
        pos = msb_first ? (3'd7 - idx) : idx;
        return b[pos];
    endfunction

endpackage

// File: rtl/entropy_serial_tx_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo2
// Two-entry first-in first-out byte queue with a registered occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset (empties the queue)
//   push_i     : write wdata_i this cycle (ignored when full)
//   wdata_i    : byte to write
//   pop_i      : drop the head entry this cycle (ignored when empty)
//   rdata_o    : head entry, valid whenever empty_o is low
//   full_o     : both entries occupied
//   empty_o    : no entries occupied
//   count_o    : occupancy 0..2
// Push and pop in the same cycle are legal at any occupancy the guards allow.
// -----------------------------------------------------------------------------
module byte_fifo2
    import entropy_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o
);

    logic [BYTE_W-1:0] mem_q [FIFO_DEPTH];
    logic              wr_ptr_q;
    logic              wr_ptr_d;
    logic              rd_ptr_q;
    logic              rd_ptr_d;
    logic [1:0]        count_q;
    logic [1:0]        count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_q == gi[0])) begin
                    mem_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/entropy_serial_tx.sv
// -----------------------------------------------------------------------------
// entropy_serial_tx
// Bit-serial transmitter for entropy bytes. Bytes arrive over a valid/ready
// handshake, wait in a 2-entry queue, and leave one bit per strobe period on
// ser_data, framed by ser_frame. The receiver samples ser_data on the rising
// edge of ser_clk; ser_data only changes while ser_clk is low.
//   Parameters:
//     DIV       : system clocks per strobe half-period (1..255)
//     MSB_FIRST : 1 = bit 7 first, 0 = bit 0 first
//     GAP       : idle cycles with ser_frame low between bytes (1..255)
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en         : transmit enable (gates acceptance and byte starts)
//     in_byte    : byte to send
//     in_valid   : in_byte valid
//     in_ready   : byte can be accepted this cycle
//     ser_data   : serial data
//     ser_clk    : serial strobe
//     ser_frame  : high while a byte is on the line
//     busy       : FSM active or queue non-empty
//     bytes_sent : wrapping count of completed bytes
// -----------------------------------------------------------------------------
module entropy_serial_tx
    import entropy_pkg::*;
#(
    parameter int unsigned DIV       = 4,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned GAP       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_frame,
    output logic              busy,
    output logic [7:0]        bytes_sent
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
    localparam logic       MSB_SEL  = (MSB_FIRST != 0);

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic [2:0]        idx_q;
    logic [2:0]        idx_d;
    logic [BYTE_W-1:0] shreg_q;
    logic [BYTE_W-1:0] shreg_d;
    logic              data_q;
    logic              data_d;
    logic              clk_q;
    logic              frame_q;
    logic              busy_q;
    logic [7:0]        sent_q;
    logic              run_q;

    logic              push;
    logic              pop;
    logic              sent_inc;
    logic [BYTE_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [1:0]        fifo_count_next;

    // run_q is cleared by reset, so in_ready stays low while rst_n is
    // asserted even if en is held high by the upstream logic.
    assign in_ready = run_q && en && !fifo_full;
    assign push     = in_valid && in_ready;

    byte_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (in_byte),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Occupancy the queue will hold after this edge; busy is registered from
    // it so it lines up with the state register.
    assign fifo_count_next = fifo_count + {1'b0, push} - {1'b0, pop};

    // -------------------------------------------------------------------------
    // Next-state logic: half-period / gap counter, bit index, shift register.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        pop      = 1'b0;
        sent_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (en && !fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    idx_d   = 3'd0;
                    state_d = ST_LOW;
                end
            end

            ST_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (idx_q != 3'd7) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_LOW;
                    end else begin
                        sent_inc = 1'b1;
                        state_d  = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 8'd0;
                    // Chain straight into the next byte when one is waiting,
                    // skipping the extra IDLE cycle.
                    if (en && !fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        idx_d   = 3'd0;
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Line data follows the state being entered: the bit is set up on entry
    // to LOW and frozen through HIGH so it never moves while ser_clk is high.
    always_comb begin
        data_d = 1'b0;
        case (state_d)
            ST_LOW:  data_d = sel_bit(shreg_d, idx_d, MSB_SEL);
            ST_HIGH: data_d = data_q;
            default: data_d = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shreg_q <= '0;
            data_q  <= 1'b0;
            clk_q   <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            sent_q  <= 8'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            clk_q   <= (state_d == ST_HIGH);
            frame_q <= (state_d == ST_LOW) || (state_d == ST_HIGH);
            busy_q  <= (state_d != ST_IDLE) || (fifo_count_next != 2'd0);
            run_q   <= 1'b1;
            if (sent_inc) begin
                sent_q <= sent_q + 8'd1;
            end
        end
    end

    assign ser_data   = data_q;
    assign ser_clk    = clk_q;
    assign ser_frame  = frame_q;
    assign busy       = busy_q;
    assign bytes_sent = sent_q;

endmodule

// File: tb/tb_entropy_serial_tx.sv
module tb_entropy_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = 8'h00;

    logic       in_ready_m, ser_data_m, ser_clk_m, ser_frame_m, busy_m;
    logic [7:0] sent_m;
    logic       in_ready_l, ser_data_l, ser_clk_l, ser_frame_l, busy_l;
    logic [7:0] sent_l;

    logic       en_f = 1'b0;
    logic       in_valid_f = 1'b0;
    logic [7:0] in_byte_f = 8'h00;
    logic       in_ready_f, ser_data_f, ser_clk_f, ser_frame_f, busy_f;
    logic [7:0] sent_f;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit rx_m[$];
    bit rx_l[$];

    always #5 clk = ~clk;

    entropy_serial_tx #(.DIV(4), .MSB_FIRST(1), .GAP(4)) dut_m (
        .clk(clk), .rst_n(rst_n), .en(en), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready_m), .ser_data(ser_data_m), .ser_clk(ser_clk_m),
        .ser_frame(ser_frame_m), .busy(busy_m), .bytes_sent(sent_m)
    );

    entropy_serial_tx #(.DIV(4), .MSB_FIRST(0), .GAP(4)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready_l), .ser_data(ser_data_l), .ser_clk(ser_clk_l),
        .ser_frame(ser_frame_l), .busy(busy_l), .bytes_sent(sent_l)
    );

    entropy_serial_tx #(.DIV(1), .MSB_FIRST(1), .GAP(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .en(en_f), .in_byte(in_byte_f), .in_valid(in_valid_f),
        .in_ready(in_ready_f), .ser_data(ser_data_f), .ser_clk(ser_clk_f),
        .ser_frame(ser_frame_f), .busy(busy_f), .bytes_sent(sent_f)
    );

    // Receivers: capture data at each strobe rising edge
    always @(posedge ser_clk_m) rx_m.push_back(ser_data_m);
    always @(posedge ser_clk_l) rx_l.push_back(ser_data_l);

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic take_m(output logic [7:0] b);
        b = 'x;
        if (rx_m.size() >= 8) begin
            for (int i = 0; i < 8; i++) b = {b[6:0], rx_m.pop_front()};
        end
    endtask

    task automatic take_l(output logic [7:0] b);
        b = 'x;
        if (rx_l.size() >= 8) begin
            for (int i = 0; i < 8; i++) b[i] = rx_l.pop_front();
        end
    endtask

    task automatic wait_sent_m(input string tag, input logic [7:0] target, input int limit);
        int n;
        n = 0;
        while (sent_m !== target && n < limit) begin
            step();
            n++;
        end
        check8(tag, sent_m, target);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while ((busy_m !== 1'b0 || busy_l !== 1'b0) && n < limit) begin
            step();
            n++;
        end
        check1(tag, busy_m, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] vals [4];
        int acc_cyc [4];
        int idx;
        int acc;
        int guard;
        logic prev_clk;
        logic prev_data;
        logic r;

        // ---------------- reset state ----------------
        en = 1'b1;
        en_f = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_ser_data", ser_data_m, 1'b0);
        check1("rst_ser_clk", ser_clk_m, 1'b0);
        check1("rst_ser_frame", ser_frame_m, 1'b0);
        check1("rst_busy", busy_m, 1'b0);
        check1("rst_in_ready", in_ready_m, 1'b0);
        check8("rst_bytes_sent", sent_m, 8'h00);
        rst_n = 1'b1;
        step();
        step();
        check1("post_rst_in_ready", in_ready_m, 1'b1);

        // ---------------- single byte 0xA5 ----------------
        rx_m.delete();
        rx_l.delete();
        cyc = 0;
        prev_clk = 1'b0;
        prev_data = 1'b0;
        in_byte = 8'hA5;
        in_valid = 1'b1;
        for (int k = 0; k < 76; k++) begin
            check1("t1_frame", ser_frame_m, (k >= 2 && k <= 65));
            check1("t1_clk", ser_clk_m, (k >= 2 && k <= 65 && ((k - 2) % 8) >= 4));
            if (prev_clk && ser_clk_m) check1("t1_data_stable", ser_data_m, prev_data);
            if (k == 65) check8("t1_sent_c65", sent_m, 8'd0);
            if (k == 66) check8("t1_sent_c66", sent_m, 8'd1);
            if (k == 69) check1("t1_busy_c69", busy_m, 1'b1);
            if (k == 70) check1("t1_busy_c70", busy_m, 1'b0);
            prev_clk = ser_clk_m;
            prev_data = ser_data_m;
            step();
            in_valid = 1'b0;
        end
        checki("t1_bit_count", rx_m.size(), 8);
        take_m(got);
        check8("t1_msb_byte", got, 8'hA5);
        take_l(got);
        check8("t1_lsb_byte", got, 8'hA5);

        // ---------------- LSB-first 0x01 ----------------
        in_byte = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_sent_m("t2_sent", 8'd2, 200);
        wait_idle("t2_idle", 50);
        checki("t2_lsb_bit_count", rx_l.size(), 8);
        if (rx_l.size() >= 2) begin
            check1("t2_lsb_bit0", rx_l[0], 1'b1);
            check1("t2_lsb_bit1", rx_l[1], 1'b0);
            check1("t2_msb_bit0", rx_m[0], 1'b0);
            check1("t2_msb_bit7", rx_m[7], 1'b1);
        end
        take_l(got);
        check8("t2_lsb_byte", got, 8'h01);
        take_m(got);
        check8("t2_msb_byte", got, 8'h01);

        // ---------------- back-to-back ----------------
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) acc_cyc[i] = -1;
        idx = 0;
        for (int k = 0; k < 300 && idx < 4; k++) begin
            in_byte = vals[idx];
            in_valid = 1'b1;
            if (k == 3) check1("t3_ready_c3", in_ready_m, 1'b0);
            if (k == 69) check1("t3_frame_c69", ser_frame_m, 1'b0);
            if (k == 70) check1("t3_frame_c70", ser_frame_m, 1'b1);
            r = in_ready_m;
            step();
            if (r) begin
                acc_cyc[idx] = k;
                idx++;
            end
        end
        in_valid = 1'b0;
        checki("t3_accept0", acc_cyc[0], 0);
        checki("t3_accept1", acc_cyc[1], 1);
        checki("t3_accept2", acc_cyc[2], 2);
        checki("t3_accept3", acc_cyc[3], 70);
        wait_sent_m("t3_sent", 8'd6, 400);
        wait_idle("t3_idle", 50);
        for (int i = 0; i < 4; i++) begin
            take_m(got);
            check8("t3_msb_order", got, vals[i]);
            take_l(got);
            check8("t3_lsb_order", got, vals[i]);
        end

        // ---------------- en drop ----------------
        vals[0] = 8'hA1;
        vals[1] = 8'hB2;
        vals[2] = 8'hC3;
        for (int k = 0; k <= 100; k++) begin
            if (k < 3) begin
                in_byte = vals[k];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (k == 20) en = 1'b0;
            if (k == 2) check1("t4_ready_c2", in_ready_m, 1'b1);
            if (k == 25) check1("t4_ready_en_low", in_ready_m, 1'b0);
            if (k == 65) check1("t4_frame_c65", ser_frame_m, 1'b1);
            if (k >= 66) check1("t4_frame_held_low", ser_frame_m, 1'b0);
            if (k == 70) check1("t4_busy_c70", busy_m, 1'b1);
            step();
        end
        check8("t4_sent_held", sent_m, 8'd7);
        en = 1'b1;
        wait_sent_m("t4_sent_resume", 8'd9, 400);
        wait_idle("t4_idle", 50);
        for (int i = 0; i < 3; i++) begin
            take_m(got);
            check8("t4_msb_byte", got, vals[i]);
            take_l(got);
            check8("t4_lsb_byte", got, vals[i]);
        end

        // ---------------- reset mid-byte ----------------
        cyc = 0;
        in_byte = 8'h77;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (cyc < 30) step();
        #2;
        rst_n = 1'b0;
        #1;
        check1("t5_rst_frame", ser_frame_m, 1'b0);
        check1("t5_rst_clk", ser_clk_m, 1'b0);
        check1("t5_rst_data", ser_data_m, 1'b0);
        check1("t5_rst_busy", busy_m, 1'b0);
        check1("t5_rst_ready", in_ready_m, 1'b0);
        check8("t5_rst_sent", sent_m, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        rx_m.delete();
        rx_l.delete();
        step();
        step();
        check1("t5_ready_after", in_ready_m, 1'b1);
        check1("t5_fifo_empty", busy_m, 1'b0);
        in_byte = 8'h5A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_sent_m("t5_sent", 8'd1, 200);
        wait_idle("t5_idle", 50);
        take_m(got);
        check8("t5_msb_byte", got, 8'h5A);
        take_l(got);
        check8("t5_lsb_byte", got, 8'h5A);

        // ---------------- DIV=1 toggle and wrap ----------------
        in_byte_f = 8'hC3;
        in_valid_f = 1'b1;
        for (int k = 0; k < 21; k++) begin
            check1("t6_clk", ser_clk_f, (k >= 2 && k <= 17 && ((k - 2) % 2) == 1));
            check1("t6_frame", ser_frame_f, (k >= 2 && k <= 17));
            step();
            in_valid_f = 1'b0;
        end
        check8("t6_sent_one", sent_f, 8'd1);
        acc = 0;
        guard = 0;
        in_valid_f = 1'b1;
        while (acc < 255 && guard < 20000) begin
            in_byte_f = acc[7:0];
            r = in_ready_f;
            step();
            if (r) acc++;
            guard++;
        end
        in_valid_f = 1'b0;
        checki("t6_accepted", acc, 255);
        guard = 0;
        while (busy_f !== 1'b0 && guard < 20000) begin
            step();
            guard++;
        end
        check1("t6_idle", busy_f, 1'b0);
        check8("t6_wrap", sent_f, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
